// File: rtl/f2if2o_pkg.sv
// Shared types and helpers for the f2if2o write-side arbiter.
// Holds the flush FSM state encoding and a small popcount.
package f2if2o_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [1:0] popcnt2(
    input logic [1:0] v
  );
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/f2if2o_wr_arb_rr_pick2.sv
// Combinational round-robin picker: first two valid requesters
// scanning cyclically from ptr, never wrapping past ptr.
module rr_pick2 #(
  parameter int NUM_REQ       = 4,
  parameter int REQ_IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]       valid,
  input  logic [REQ_IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]       pick1,
  output logic [NUM_REQ-1:0]       pick2,
  output logic [REQ_IDX_WIDTH-1:0] idx1,
  output logic [REQ_IDX_WIDTH-1:0] idx2
);

  logic                     f1;
  logic                     f2;
  logic [REQ_IDX_WIDTH-1:0] sel;

  always_comb begin
    pick1 = '0;
    pick2 = '0;
    idx1  = '0;
    idx2  = '0;
    f1    = 1'b0;
    f2    = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = REQ_IDX_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (valid[sel]) begin
        if (!f1) begin
          f1         = 1'b1;
          pick1[sel] = 1'b1;
          idx1       = sel;
        end else if (!f2) begin
          f2         = 1'b1;
          pick2[sel] = 1'b1;
          idx2       = sel;
        end
      end
    end
  end

endmodule

// File: rtl/f2if2o_wr_arb.sv
// Round-robin write scheduler for the dual-port f2if2o FIFO:
// up to two grants per cycle, bounded by free space, with flush drain.
module f2if2o_wr_arb
  import f2if2o_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int REQ_IDX_WIDTH   = 2,
  parameter int FIFO_SIZE       = 32,
  parameter int FIFO_SIZE_WIDTH = 5,
  parameter int FIFO_DATA_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*FIFO_DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [FIFO_SIZE_WIDTH:0]           fifo_num_i,
  input  logic                               flush_i,
  output logic                               flush_done_o,
  output logic                               wr_first_en_o,
  output logic                               wr_second_en_o,
  output logic [FIFO_DATA_WIDTH-1:0]         wdata_first_o,
  output logic [FIFO_DATA_WIDTH-1:0]         wdata_second_o
);

  localparam int FW = FIFO_SIZE_WIDTH + 2;

  state_e                   state;
  state_e                   state_nxt;
  logic [REQ_IDX_WIDTH-1:0] rr_ptr;
  logic [REQ_IDX_WIDTH-1:0] idx1;
  logic [REQ_IDX_WIDTH-1:0] idx2;
  logic [REQ_IDX_WIDTH-1:0] last;
  logic [NUM_REQ-1:0]       pick1;
  logic [NUM_REQ-1:0]       pick2;
  logic [FW-1:0]            used;
  logic [FW-1:0]            free;
  logic [1:0]               inflight;
  logic [1:0]               limit;
  logic                     g1;
  logic                     g2;
  logic                     empty;

  rr_pick2 #(
    .NUM_REQ       (NUM_REQ),
    .REQ_IDX_WIDTH (REQ_IDX_WIDTH)
  ) u_pick (
    .valid (req_valid_i),
    .ptr   (rr_ptr),
    .pick1 (pick1),
    .pick2 (pick2),
    .idx1  (idx1),
    .idx2  (idx2)
  );

  // fifo_num_i lags our registered writes by a cycle
  assign inflight = popcnt2({wr_second_en_o, wr_first_en_o});
  assign used     = FW'(fifo_num_i) + FW'(inflight);
  assign free     = (FW'(FIFO_SIZE) > used) ? FW'(FIFO_SIZE) - used : '0;
  assign empty    = (fifo_num_i == '0) && !wr_first_en_o && !wr_second_en_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (flush_i) state_nxt = DRAIN;
      DRAIN:   if (empty)   state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    limit        = 2'd0;
    flush_done_o = 1'b0;
    unique case (state)
      RUN: begin
        if (!flush_i)
          limit = (free >= FW'(2)) ? 2'd2 : free[1:0];
      end
      DRAIN:   limit = 2'd0;
      DONE:    flush_done_o = 1'b1;
      default: limit = 2'd0;
    endcase
  end

  assign g1   = (|pick1) && (limit != 2'd0);
  assign g2   = (|pick2) && (limit == 2'd2);
  assign last = g2 ? idx2 : idx1;

  // Gated by rst_n so no requester sees a grant while held in reset
  assign req_ready_o = rst_n
    ? (({NUM_REQ{g1}} & pick1) | ({NUM_REQ{g2}} & pick2))
    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      wr_first_en_o  <= 1'b0;
      wr_second_en_o <= 1'b0;
      wdata_first_o  <= '0;
      wdata_second_o <= '0;
    end else begin
      wr_first_en_o  <= g1;
      wr_second_en_o <= g2;
      if (g1)
        wdata_first_o <=
          req_data_i[int'(idx1)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
      if (g2)
        wdata_second_o <=
          req_data_i[int'(idx2)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
      if (g1)
        rr_ptr <= (last == REQ_IDX_WIDTH'(NUM_REQ - 1))
          ? '0 : last + 1'b1;
    end
  end

endmodule

// File: tb/tb_f2if2o_wr_arb.sv
// Directed bench for f2if2o_wr_arb: vector table plus
// overflow, flush and async-reset sequences.
module tb_f2if2o_wr_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid_i;
  logic [19:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic [5:0]  fifo_num_i;
  logic        flush_i;
  logic        flush_done_o;
  logic        wr_first_en_o;
  logic        wr_second_en_o;
  logic [4:0]  wdata_first_o;
  logic [4:0]  wdata_second_o;

  int n_cmp = 0;
  int n_bad = 0;

  f2if2o_wr_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_ready_o    (req_ready_o),
    .fifo_num_i     (fifo_num_i),
    .flush_i        (flush_i),
    .flush_done_o   (flush_done_o),
    .wr_first_en_o  (wr_first_en_o),
    .wr_second_en_o (wr_second_en_o),
    .wdata_first_o  (wdata_first_o),
    .wdata_second_o (wdata_second_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] valid;
    logic [5:0] num;
    logic       flush;
    logic [3:0] rdy;
    logic       fen;
    logic       sen;
    logic [4:0] fd;
    logic [4:0] sd;
    logic       done;
  } vec_t;

  vec_t vt[18];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    req_valid_i = 4'h0;
    flush_i     = 1'b0;
    fifo_num_i  = 6'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int occ;
  int ovf;
  int dcnt;
  int dcyc;

  initial begin
    // data of requester i is 10+i
    req_data_i  = {5'd13, 5'd12, 5'd11, 5'd10};
    rst_n       = 1'b0;
    req_valid_i = 4'hF;
    fifo_num_i  = 6'd0;
    flush_i     = 1'b0;

    vt[0]  = '{4'hF, 6'd0,  1'b0, 4'h3, 1'b1, 1'b1, 5'd10, 5'd11, 1'b0};
    vt[1]  = '{4'hF, 6'd0,  1'b0, 4'hC, 1'b1, 1'b1, 5'd12, 5'd13, 1'b0};
    vt[2]  = '{4'hF, 6'd2,  1'b0, 4'h3, 1'b1, 1'b1, 5'd10, 5'd11, 1'b0};
    vt[3]  = '{4'h4, 6'd4,  1'b0, 4'h4, 1'b1, 1'b0, 5'd12, 5'd0,  1'b0};
    vt[4]  = '{4'h5, 6'd5,  1'b0, 4'h5, 1'b1, 1'b1, 5'd10, 5'd12, 1'b0};
    vt[5]  = '{4'h0, 6'd7,  1'b0, 4'h0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0};
    vt[6]  = '{4'hF, 6'd31, 1'b0, 4'h8, 1'b1, 1'b0, 5'd13, 5'd0,  1'b0};
    vt[7]  = '{4'hF, 6'd31, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0};
    vt[8]  = '{4'hF, 6'd30, 1'b0, 4'h3, 1'b1, 1'b1, 5'd10, 5'd11, 1'b0};
    vt[9]  = '{4'hF, 6'd30, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0};
    vt[10] = '{4'hF, 6'd32, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0};
    vt[11] = '{4'h2, 6'd0,  1'b0, 4'h2, 1'b1, 1'b0, 5'd11, 5'd0,  1'b0};
    vt[12] = '{4'h9, 6'd1,  1'b0, 4'h9, 1'b1, 1'b1, 5'd13, 5'd10, 1'b0};
    vt[13] = '{4'hF, 6'd3,  1'b1, 4'h0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0};
    vt[14] = '{4'hF, 6'd3,  1'b0, 4'h0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0};
    vt[15] = '{4'hF, 6'd0,  1'b0, 4'h0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1};
    vt[16] = '{4'hF, 6'd0,  1'b0, 4'h0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0};
    vt[17] = '{4'hF, 6'd0,  1'b0, 4'h6, 1'b1, 1'b1, 5'd11, 5'd12, 1'b0};

    #3;
    check("rst ready", 32'(req_ready_o), 32'h0);
    check("rst fen", 32'(wr_first_en_o), 32'h0);
    check("rst sen", 32'(wr_second_en_o), 32'h0);
    check("rst fdata", 32'(wdata_first_o), 32'h0);
    check("rst sdata", 32'(wdata_second_o), 32'h0);
    check("rst done", 32'(flush_done_o), 32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    req_valid_i = 4'h0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      req_valid_i = vt[i].valid;
      fifo_num_i  = vt[i].num;
      flush_i     = vt[i].flush;
      #1;
      check($sformatf("row%0d ready", i), 32'(req_ready_o), 32'(vt[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("row%0d fen", i), 32'(wr_first_en_o), 32'(vt[i].fen));
      check($sformatf("row%0d sen", i), 32'(wr_second_en_o), 32'(vt[i].sen));
      check($sformatf("row%0d done", i), 32'(flush_done_o), 32'(vt[i].done));
      if (vt[i].fen)
        check($sformatf("row%0d fdata", i), 32'(wdata_first_o), 32'(vt[i].fd));
      if (vt[i].sen)
        check($sformatf("row%0d sdata", i), 32'(wdata_second_o), 32'(vt[i].sd));
    end

    // burst from full-2 against a FIFO occupancy model
    do_reset();
    occ = 30;
    ovf = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid_i = (c < 3) ? 4'hF : 4'h0;
      fifo_num_i  = 6'(occ);
      @(posedge clk);
      #1;
      occ = occ + int'(wr_first_en_o) + int'(wr_second_en_o);
      if (occ > 32) ovf++;
    end
    check("burst occ", 32'(occ), 32'd32);
    check("burst ovf", 32'(ovf), 32'd0);

    // flush with 5 queued, reader draining one per cycle
    do_reset();
    occ  = 5;
    dcnt = 0;
    dcyc = -1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req_valid_i = 4'hF;
      flush_i     = (c == 0);
      fifo_num_i  = 6'(occ);
      #1;
      if (c <= 6)
        check($sformatf("flush c%0d ready", c), 32'(req_ready_o), 32'h0);
      if (c == 7)
        check("flush resume ready", 32'(req_ready_o), 32'h3);
      @(posedge clk);
      #1;
      if (occ > 0) occ--;
      if (flush_done_o) begin
        dcnt++;
        dcyc = c;
      end
    end
    check("flush done count", 32'(dcnt), 32'd1);
    check("flush done cycle", 32'(dcyc), 32'd5);

    // async reset mid-burst
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req_valid_i = 4'hF;
      fifo_num_i  = 6'd0;
    end
    @(posedge clk);
    #1;
    check("pre-rst fen", 32'(wr_first_en_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst fen", 32'(wr_first_en_o), 32'h0);
    check("arst sen", 32'(wr_second_en_o), 32'h0);
    check("arst fdata", 32'(wdata_first_o), 32'h0);
    check("arst ready", 32'(req_ready_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst ready", 32'(req_ready_o), 32'h3);
    @(posedge clk);
    #1;
    check("post-rst fdata", 32'(wdata_first_o), 32'd10);
    check("post-rst sdata", 32'(wdata_second_o), 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
